irq_controller: RTL and testbench

IRQ_CONTROLLER -- requirements
Module: irq_controller

---
 rtl/irq_controller.sv | 94 +++++++++
 tb/tb_irq_controller.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/irq_controller.sv
// irq_controller: prioritized interrupt controller with per-line sync, edge/level modes and req/ack handshake
// Ports:
//   clk, rst           clock; asynchronous active-high reset
//   irq_in[N_IRQ]      raw asynchronous interrupt lines
//   cfg_we, cfg_sel    config write strobe; target 0=enable, 1=mode (1=edge), 2=pending W1C, 3=none
//   cfg_wdata[N_IRQ]   config write data
//   int_req, int_id    request to core and index of the requesting line (valid while int_req=1)
//   int_ack            one-cycle acknowledge from core
//   pending, enable    current pending vector (unmasked) and enable register
module irq_controller #(
   parameter int N_IRQ       = 4,
   parameter int ID_W        = 2,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_IRQ-1:0] irq_in,
   input  logic             cfg_we,
   input  logic [1:0]       cfg_sel,
   input  logic [N_IRQ-1:0] cfg_wdata,
   output logic             int_req,
   output logic [ID_W-1:0]  int_id,
   input  logic             int_ack,
   output logic [N_IRQ-1:0] pending,
   output logic [N_IRQ-1:0] enable
);
   typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;
   state_t state_q;
   logic [SYNC_STAGES-1:0][N_IRQ-1:0] sync_q, sync_d;
   logic [N_IRQ-1:0] prev_q, prev_d, edge_q, edge_d, enable_q, enable_d, mode_q, mode_d;
   logic [N_IRQ-1:0] sync, rise, clr, cand;
   logic [ID_W-1:0]  id_q, win;
   logic             req_q;
   always_comb begin
      sync_d   = {sync_q[SYNC_STAGES-2:0], irq_in};
      sync     = sync_q[SYNC_STAGES-1];
      prev_d   = sync;
      rise     = sync & ~prev_q;
      // software W1C plus the clear implied by acknowledging the current request
      clr      = ((cfg_we && cfg_sel == 2'd2) ? cfg_wdata : '0)
               | ((state_q == REQ && int_ack) ? (N_IRQ'(1) << id_q) : '0);
      // a rising edge beats a same-cycle clear; edge state is kept only for edge-mode lines
      edge_d   = mode_q & (rise | (edge_q & ~clr));
      enable_d = (cfg_we && cfg_sel == 2'd0) ? cfg_wdata : enable_q;
      mode_d   = (cfg_we && cfg_sel == 2'd1) ? cfg_wdata : mode_q;
      pending  = (mode_q & edge_q) | (~mode_q & sync);
      enable   = enable_q;
      cand     = pending & enable_q;
      win      = '0;
      for (int i = N_IRQ - 1; i >= 0; i--) win = cand[i] ? ID_W'(i) : win;
      int_req  = req_q;
      int_id   = id_q;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q   <= '0;
         prev_q   <= '0;
         edge_q   <= '0;
         enable_q <= '0;
         mode_q   <= '0;
      end else begin
         sync_q   <= sync_d;
         prev_q   <= prev_d;
         edge_q   <= edge_d;
         enable_q <= enable_d;
         mode_q   <= mode_d;
      end
   end
   // SERVICE always leaves after one cycle; arbitration for the next request is done as it
   // leaves, so back-to-back requests are separated by exactly one int_req=0 cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         id_q    <= '0;
         req_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE, SERVICE: begin
               state_q <= (|cand) ? REQ : IDLE;
               req_q   <= |cand;
               id_q    <= (|cand) ? win : id_q;
            end
            REQ: begin
               state_q <= int_ack ? SERVICE : (enable_q[id_q] ? REQ : IDLE);
               req_q   <= !int_ack && enable_q[id_q];
            end
            default: begin
               state_q <= IDLE;
               req_q   <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_irq_controller.sv
// tb_irq_controller: directed self-checking bench for irq_controller
module tb_irq_controller;
   logic       clk, rst, cfg_we, int_req, int_ack;
   logic [3:0] irq_in, cfg_wdata, pending, enable;
   logic [1:0] cfg_sel, int_id;
   int         n_cmp = 0;
   int         n_bad = 0;
   irq_controller dut (
      .clk(clk), .rst(rst), .irq_in(irq_in), .cfg_we(cfg_we), .cfg_sel(cfg_sel),
      .cfg_wdata(cfg_wdata), .int_req(int_req), .int_id(int_id), .int_ack(int_ack),
      .pending(pending), .enable(enable)
   );
   initial clk = 1'b0;
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic cfg_wr(input logic [1:0] sel, input logic [3:0] data);
      cfg_we = 1'b1;
      cfg_sel = sel;
      cfg_wdata = data;
      tick;
      cfg_we = 1'b0;
   endtask
   task automatic pulse(input logic [3:0] v);
      irq_in = v;
      tick;
      tick;
      tick;
      irq_in = '0;
   endtask
   task automatic ack;
      int_ack = 1'b1;
      tick;
      int_ack = 1'b0;
   endtask
   initial begin
      rst = 1'b1; irq_in = '0; cfg_we = 1'b0; cfg_sel = '0; cfg_wdata = '0; int_ack = 1'b0;
      tick;
      tick;
      check("rst_req", int_req, 0);
      check("rst_id", int_id, 0);
      check("rst_pend", pending, 0);
      check("rst_en", enable, 0);
      rst = 1'b0;
      tick;
      check("post_rst_req", int_req, 0);
      check("post_rst_pend", pending, 0);
      cfg_wr(2'd0, 4'b1111);
      cfg_wr(2'd1, 4'b1111);
      check("en_write", enable, 4'b1111);
      // single edge on line 2: request four edges after first sample
      pulse(4'b0100);
      check("lat_e3_req", int_req, 0);
      check("lat_e3_pend", pending, 4'b0100);
      tick;
      check("lat_e4_req", int_req, 1);
      check("lat_e4_id", int_id, 2);
      ack;
      check("ack2_req", int_req, 0);
      check("ack2_pend", pending, 0);
      tick;
      check("ack2_idle1", int_req, 0);
      tick;
      check("ack2_idle2", int_req, 0);
      check("id_hold", int_id, 2);
      // all four lines: serviced lowest index first
      pulse(4'b1111);
      check("all_pend", pending, 4'b1111);
      tick;
      for (int k = 0; k < 4; k++) begin
         check("all_req", int_req, 1);
         check("all_id", int_id, k);
         ack;
         check("all_svc_req", int_req, 0);
         check("all_svc_pend", pending, 4'b1111 & (4'b1111 << (k + 1)));
         tick;
      end
      check("all_end_req", int_req, 0);
      check("all_end_pend", pending, 0);
      // line 3 level mode: re-requested while high
      cfg_wr(2'd1, 4'b0111);
      irq_in = 4'b1000;
      tick;
      tick;
      tick;
      check("lvl_req", int_req, 1);
      check("lvl_id", int_id, 3);
      ack;
      check("lvl_svc_req", int_req, 0);
      check("lvl_svc_pend", pending, 4'b1000);
      tick;
      check("lvl_rereq", int_req, 1);
      check("lvl_reid", int_id, 3);
      irq_in = '0;
      tick;
      tick;
      check("lvl_low_pend", pending, 0);
      check("lvl_held", int_req, 1);
      ack;
      check("lvl_done0", int_req, 0);
      tick;
      check("lvl_done1", int_req, 0);
      tick;
      check("lvl_done2", int_req, 0);
      cfg_wr(2'd1, 4'b1111);
      // withdraw on disable, return on re-enable
      pulse(4'b0010);
      tick;
      check("wd_req", int_req, 1);
      check("wd_id", int_id, 1);
      cfg_wr(2'd0, 4'b1101);
      check("wd_en", enable, 4'b1101);
      tick;
      check("wd_drop", int_req, 0);
      check("wd_pend", pending, 4'b0010);
      tick;
      check("wd_stay", int_req, 0);
      cfg_wr(2'd0, 4'b1111);
      tick;
      check("wd_back_req", int_req, 1);
      check("wd_back_id", int_id, 1);
      ack;
      tick;
      check("wd_clean_pend", pending, 0);
      // masked pending line, ignored ack, no-op write, software clear
      cfg_wr(2'd0, 4'b1110);
      pulse(4'b0001);
      tick;
      check("mask_req", int_req, 0);
      check("mask_pend", pending, 4'b0001);
      ack;
      check("idle_ack_pend", pending, 4'b0001);
      cfg_wr(2'd3, 4'b0000);
      check("sel3_en", enable, 4'b1110);
      check("sel3_pend", pending, 4'b0001);
      cfg_wr(2'd2, 4'b0001);
      check("w1c_pend", pending, 0);
      cfg_wr(2'd0, 4'b1111);
      // set and clear of line 0 in the same cycle: set wins
      irq_in = 4'b0001;
      tick;
      tick;
      cfg_we = 1'b1; cfg_sel = 2'd2; cfg_wdata = 4'b0001;
      tick;
      cfg_we = 1'b0;
      irq_in = '0;
      check("setwin_pend", pending, 4'b0001);
      tick;
      check("setwin_req", int_req, 1);
      check("setwin_id", int_id, 0);
      ack;
      tick;
      // asynchronous reset in the middle of a request
      pulse(4'b0100);
      tick;
      check("arst_pre_req", int_req, 1);
      check("arst_pre_id", int_id, 2);
      #2 rst = 1'b1;
      #1;
      check("arst_req", int_req, 0);
      check("arst_en", enable, 0);
      check("arst_pend", pending, 0);
      tick;
      rst = 1'b0;
      repeat (6) tick;
      check("arst_after_req", int_req, 0);
      check("arst_after_pend", pending, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
